// File: rtl/latch_reader.sv
// Samples an asynchronous writer-side latch: a synchronised fall of en captures data into a show-ahead FIFO.
// Optional build macro LATCH_READER_FILTER_EN requires en to stay low for two synchronised samples before capture.
module latch_reader #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [DW-1:0]            data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_en_d;
    logic          w_close;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_en_d  <= 1'b0;
        end else begin
            r_sync1 <= en;
            r_sync2 <= r_sync1;
            r_en_d  <= r_sync2;
        end
    end

`ifdef LATCH_READER_FILTER_EN
    logic r_en_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_d2 <= 1'b0;
        end else begin
            r_en_d2 <= r_en_d;
        end
    end

    // High, then low on two consecutive synchronised samples.
    assign w_close = r_en_d2 & ~r_en_d & ~r_sync2;
`else
    assign w_close = r_en_d & ~r_sync2;
`endif

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = ~w_empty & rd_ready;
    // A pop frees the slot the full-FIFO push lands in, so both are accepted.
    assign w_push  = w_close & (~w_full | w_pop);
    assign w_drop  = w_close & w_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_valid = ~w_empty;
    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_latch_reader.sv
// Bench for latch_reader: directed scenarios plus random en/rd_ready traffic against a queue-based reference.
module tb_latch_reader;

`ifdef LATCH_READER_FILTER_EN
    localparam int  LAT    = 3;
    localparam bit  FILTER = 1'b1;
`else
    localparam int  LAT    = 2;
    localparam bit  FILTER = 1'b0;
`endif
    localparam int  DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] data = '0;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [2:0] count;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    latch_reader #(.DW(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .data     (data),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference: en history per edge, word queue, sticky overflow flag.
    logic [7:0] m_q[$];
    logic [3:0] m_hist = '0;
    bit         m_ovf = 1'b0;
    bit         m_close, m_pop, m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_hist = '0;
            m_ovf  = 1'b0;
        end else begin
            if (FILTER) m_close = m_hist[3] & ~m_hist[2] & ~m_hist[1];
            else        m_close = m_hist[2] & ~m_hist[1];
            m_pop  = (m_q.size() != 0) && rd_ready;
            m_drop = m_close && (m_q.size() == DEPTH) && !m_pop;
            if (m_pop) void'(m_q.pop_front());
            if (m_close && !m_drop) m_q.push_back(data);
            if (m_drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_hist = {m_hist[2:0], en};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("valid", 32'(rd_valid), 32'(m_q.size() != 0));
        check("data",  32'(rd_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        check("count", 32'(count),    32'(m_q.size()));
        check("ovf",   32'(overflow), 32'(m_ovf));
    endtask

    task automatic latch_word(input logic [7:0] d);
        data = d;
        en   = 1'b1;
        tick();
        tick();
        en = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    task automatic pop_one(input logic [7:0] exp);
        check("pop_data", 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    int unsigned low_cnt;
    int unsigned exp37;

    initial begin
        // Reset state, with en high through release.
        en = 1'b1;
        tick();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data",  32'(rd_data), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Single capture latency.
        data = 8'hA5;
        en   = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            tick();
            check("lat_early", 32'(rd_valid), 32'd0);
        end
        tick();
        check("lat_valid", 32'(rd_valid), 32'd1);
        check("lat_data",  32'(rd_data), 32'hA5);
        check("lat_count", 32'(count), 32'd1);
        repeat (4) tick();
        check("one_push", 32'(count), 32'd1);
        pop_one(8'hA5);
        check("drained", 32'(count), 32'd0);

        // Five captures into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) latch_word(8'(i));
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        for (int i = 1; i <= 4; i++) pop_one(8'(i));
        check("empty", 32'(rd_valid), 32'd0);

        // Clear coincident with a drop: set wins.
        for (int i = 0; i < 4; i++) latch_word(8'h11 + 8'(i));
        data = 8'h15;
        en = 1'b1;
        ovf_clr = 1'b1;
        tick();
        tick();
        en = 1'b0;
        repeat (LAT + 1) tick();
        check("ovf_setwins", 32'(overflow), 32'd1);
        tick();
        ovf_clr = 1'b0;
        check("ovf_after", 32'(overflow), 32'd0);

        // Push and pop on the same edge while full.
        data = 8'h16;
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        repeat (LAT) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("fullpp_count", 32'(count), 32'd4);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        pop_one(8'h12);
        pop_one(8'h13);
        pop_one(8'h14);
        pop_one(8'h16);

        // One-cycle low pulse.
        en = 1'b1;
        tick();
        tick();
        data = 8'h37;
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (5) tick();
        exp37 = FILTER ? 0 : 1;
        check("pulse_count", 32'(count), exp37);
        if (count != 0) pop_one(8'h37);

        // Reset mid-operation, en low at release.
        for (int i = 0; i < 3; i++) latch_word(8'h40 + 8'(i));
        check("pre_rst", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("no_push_rel", 32'(count), 32'd0);

        // Random traffic.
        low_cnt = 10;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 599) != 0);
            if (en) begin
                if ($urandom_range(0, 2) == 0) begin
                    en = 1'b0;
                    low_cnt = 0;
                end
            end else begin
                low_cnt++;
                if (low_cnt >= 4 && $urandom_range(0, 2) == 0) begin
                    en = 1'b1;
                    data = 8'($urandom);
                end
            end
            rd_ready = ($urandom_range(0, 3) == 0);
            ovf_clr  = ($urandom_range(0, 15) == 0);
        end
        rst_n = 1'b1;
        rd_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
